// File: rtl/profile_sampler_ci.sv
// ---------------------------------------------------------------------------
// profile_sampler_ci
//
// Custom-instruction block that takes periodic snapshots of the four
// profiling counters and stores them in an on-chip FIFO. Software can then
// read back a time series instead of polling the live counters.
//
// Ports:
//   clock       system clock
//   reset       asynchronous, active-low reset
//   start       custom-instruction start strobe
//   ciN         custom-instruction number; the block answers only to customId
//   valueA      [2:0] selects the opcode, upper bits are ignored
//   valueB      operand (interval, run flag, or PEEK word index)
//   counter0..3 live counter values from the profiling block
//   done        one-cycle pulse, one cycle after each accepted instruction
//   result      instruction result, valid while done is high, zero otherwise
//   sampleIrq   high while the FIFO held at least half its depth on the
//               previous cycle
//
// Opcodes:
//   0 SETINT  interval and timer are both loaded from valueB
//   1 RUN     running <= valueB[0]; timer reloads on a 0->1 transition
//   2 PEEK    word valueB[1:0] of the head entry (0 when empty)
//   3 POP     counter0 word of the head entry, then the head is removed
//   4 STATUS  {overflow, running, 22'b0, count}
//   5 CLEAR   empties the FIFO and clears overflow
//   6,7       no effect, result 0
// ---------------------------------------------------------------------------
module profile_sampler_ci #(
    parameter logic [7:0] customId      = 8'h01,
    parameter int         fifoDepthLog2 = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  ciN,
    input  logic [31:0] valueA,
    input  logic [31:0] valueB,
    input  logic [31:0] counter0,
    input  logic [31:0] counter1,
    input  logic [31:0] counter2,
    input  logic [31:0] counter3,
    output logic        done,
    output logic [31:0] result,
    output logic        sampleIrq
);

    localparam int DEPTH = 1 << fifoDepthLog2;

    // Count value meaning "full" (count is one bit wider than the pointers).
    localparam logic [fifoDepthLog2:0] FULL_CNT = {1'b1, {fifoDepthLog2{1'b0}}};
    localparam logic [fifoDepthLog2:0] HALF_CNT = FULL_CNT >> 1;

    localparam logic [2:0] OP_SETINT = 3'd0;
    localparam logic [2:0] OP_RUN    = 3'd1;
    localparam logic [2:0] OP_PEEK   = 3'd2;
    localparam logic [2:0] OP_POP    = 3'd3;
    localparam logic [2:0] OP_STATUS = 3'd4;
    localparam logic [2:0] OP_CLEAR  = 3'd5;

    // Selects one 32-bit word of a packed FIFO entry; word 0 is counter0.
    function automatic logic [31:0] pick_word(input logic [127:0] entry,
                                              input logic [1:0]   idx);
        logic [31:0] w;
        case (idx)
            2'd0:    w = entry[31:0];
            2'd1:    w = entry[63:32];
            2'd2:    w = entry[95:64];
            default: w = entry[127:96];
        endcase
        return w;
    endfunction

    // Packs the STATUS word; the count is zero-extended into the low byte.
    function automatic logic [31:0] status_word(input logic                   ovf,
                                                input logic                   run,
                                                input logic [fifoDepthLog2:0] cnt);
        logic [7:0] cnt8;
        cnt8                    = '0;
        cnt8[fifoDepthLog2:0]   = cnt;
        return {ovf, run, 22'b0, cnt8};
    endfunction

    // -----------------------------------------------------------------------
    // Stage p0: instruction decode, sample event and FIFO bookkeeping
    // -----------------------------------------------------------------------
    logic                       sel_p0;
    logic [2:0]                 op_p0;
    logic [31:0]                result_d_p0;

    logic                       running;
    logic                       overflow;
    logic [31:0]                interval;
    logic [31:0]                timer;
    logic [fifoDepthLog2-1:0]   head;
    logic [fifoDepthLog2-1:0]   tail;
    logic [fifoDepthLog2:0]     count;
    logic [127:0]               mem [DEPTH];
    logic [127:0]               head_entry;

    logic                       sample_evt;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic                       pop_ok;
    logic                       clear_req;
    logic                       push_ok;
    logic                       drop_evt;

    logic                       unused_opcode_bits;

    assign sel_p0     = start && (ciN == customId);
    assign op_p0      = valueA[2:0];
    assign unused_opcode_bits = &{1'b0, valueA[31:3]};

    assign head_entry = mem[head];
    assign fifo_full  = (count == FULL_CNT);
    assign fifo_empty = (count == '0);

    // The timer is examined before this cycle's update, so a SETINT or RUN
    // in the same cycle does not suppress a sample that is already due.
    assign sample_evt = running && (timer == 32'd0);

    assign clear_req  = sel_p0 && (op_p0 == OP_CLEAR);
    assign pop_ok     = sel_p0 && (op_p0 == OP_POP) && !fifo_empty;

    // A pop in the same cycle frees a slot, so a full FIFO can still accept
    // the sample. CLEAR discards any concurrent sample.
    assign push_ok    = sample_evt && !clear_req && (!fifo_full || pop_ok);
    assign drop_evt   = sample_evt && !clear_req && fifo_full && !pop_ok;

    always_comb begin
        result_d_p0 = '0;
        if (sel_p0) begin
            case (op_p0)
                OP_PEEK: begin
                    if (!fifo_empty) begin
                        result_d_p0 = pick_word(head_entry, valueB[1:0]);
                    end
                end
                OP_POP: begin
                    if (!fifo_empty) begin
                        result_d_p0 = head_entry[31:0];
                    end
                end
                OP_STATUS: begin
                    result_d_p0 = status_word(overflow, running, count);
                end
                default: begin
                    result_d_p0 = '0;
                end
            endcase
        end
    end

    // FIFO storage is pure data: written only on an accepted sample and
    // never reset, since count/head/tail already define what is valid.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[tail] <= {counter3, counter2, counter1, counter0};
        end
    end

    // -----------------------------------------------------------------------
    // Stage p1: registered response and control state
    // -----------------------------------------------------------------------
    logic        done_p1;
    logic [31:0] result_p1;
    logic        irq_p1;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            done_p1   <= 1'b0;
            result_p1 <= '0;
            irq_p1    <= 1'b0;
            running   <= 1'b0;
            overflow  <= 1'b0;
            interval  <= '0;
            timer     <= '0;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
        end else begin
            done_p1   <= sel_p0;
            result_p1 <= result_d_p0;
            irq_p1    <= (count >= HALF_CNT);

            if (running) begin
                timer <= (timer == 32'd0) ? interval : (timer - 32'd1);
            end

            if (sel_p0 && (op_p0 == OP_SETINT)) begin
                interval <= valueB;
                timer    <= valueB;
            end

            if (sel_p0 && (op_p0 == OP_RUN)) begin
                running <= valueB[0];
                if (!running && valueB[0]) begin
                    timer <= interval;
                end
            end

            if (clear_req) begin
                head     <= '0;
                tail     <= '0;
                count    <= '0;
                overflow <= 1'b0;
            end else begin
                if (push_ok) begin
                    tail <= tail + 1'b1;
                end
                if (pop_ok) begin
                    head <= head + 1'b1;
                end
                if (push_ok && !pop_ok) begin
                    count <= count + 1'b1;
                end else if (!push_ok && pop_ok) begin
                    count <= count - 1'b1;
                end
                if (drop_evt) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

    assign done      = done_p1;
    assign result    = result_p1;
    assign sampleIrq = irq_p1;

endmodule

// File: tb/tb_profile_sampler_ci.sv
module tb_profile_sampler_ci;

    localparam int DEPTH = 8;

    logic        clock    = 1'b0;
    logic        reset    = 1'b1;
    logic        start    = 1'b0;
    logic [7:0]  ciN      = 8'h00;
    logic [31:0] valueA   = '0;
    logic [31:0] valueB   = '0;
    logic [31:0] counter0 = '0;
    logic [31:0] counter1 = '0;
    logic [31:0] counter2 = '0;
    logic [31:0] counter3 = '0;
    logic        done;
    logic [31:0] result;
    logic        sampleIrq;

    profile_sampler_ci #(
        .customId      (8'h01),
        .fifoDepthLog2 (3)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .ciN       (ciN),
        .valueA    (valueA),
        .valueB    (valueB),
        .counter0  (counter0),
        .counter1  (counter1),
        .counter2  (counter2),
        .counter3  (counter3),
        .done      (done),
        .result    (result),
        .sampleIrq (sampleIrq)
    );

    always #5 clock = ~clock;

    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned cyc      = 0;
    bit          rnd_cnt  = 1'b0;

    // Reference model: FIFO as a queue of snapshots, plus the run/timer state.
    typedef logic [3:0][31:0] entry_t;
    entry_t      q[$];
    bit          m_run;
    bit          m_ovf;
    logic [31:0] m_int;
    logic [31:0] m_tmr;
    logic        m_done;
    logic [31:0] m_res;
    logic        m_irq;

    typedef struct {
        bit          st;
        logic [7:0]  n;
        logic [31:0] a;
        logic [31:0] b;
        bit          ed;
        logic [31:0] er;
    } vec_t;
    vec_t tbl[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got 0x%08h expected 0x%08h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_run  = 1'b0;
        m_ovf  = 1'b0;
        m_int  = '0;
        m_tmr  = '0;
        m_done = 1'b0;
        m_res  = '0;
        m_irq  = 1'b0;
    endtask

    task automatic model_step();
        bit          sel;
        logic [2:0]  op;
        bit          smp;
        logic [31:0] nt;
        entry_t      cur;
        sel    = start && (ciN == 8'h01);
        op     = valueA[2:0];
        m_irq  = (q.size() >= DEPTH / 2);
        m_done = sel;
        m_res  = '0;
        if (sel) begin
            case (op)
                3'd2: if (q.size() > 0) m_res = q[0][valueB[1:0]];
                3'd3: if (q.size() > 0) m_res = q[0][0];
                3'd4: m_res = {m_ovf, m_run, 22'b0, 8'(q.size())};
                default: m_res = '0;
            endcase
        end
        smp = m_run && (m_tmr == 32'd0);
        if (!m_run)              nt = m_tmr;
        else if (m_tmr == 32'd0) nt = m_int;
        else                     nt = m_tmr - 32'd1;
        cur = {counter3, counter2, counter1, counter0};
        if (sel && op == 3'd5) begin
            q.delete();
            m_ovf = 1'b0;
        end else begin
            if (sel && op == 3'd3 && q.size() > 0) void'(q.pop_front());
            if (smp) begin
                if (q.size() < DEPTH) q.push_back(cur);
                else                  m_ovf = 1'b1;
            end
        end
        if (sel && op == 3'd0) begin
            m_int = valueB;
            nt    = valueB;
        end
        if (sel && op == 3'd1) begin
            if (!m_run && valueB[0]) nt = m_int;
            m_run = valueB[0];
        end
        m_tmr = nt;
    endtask

    function automatic logic [31:0] ramp2(input int unsigned c);
        return c ^ 32'hA5A5_0000;
    endfunction

    // One clock cycle: drive inputs, let the edge happen, advance the model,
    // then compare all outputs just after the edge.
    task automatic cycle(input bit st, input logic [7:0] n, input logic [31:0] a,
                         input logic [31:0] b);
        start  = st;
        ciN    = n;
        valueA = a;
        valueB = b;
        if (rnd_cnt) begin
            counter0 = $urandom;
            counter1 = $urandom;
            counter2 = $urandom;
            counter3 = $urandom;
        end else begin
            counter0 = cyc;
            counter1 = cyc * 3 + 100;
            counter2 = ramp2(cyc);
            counter3 = ~cyc;
        end
        @(posedge clock);
        model_step();
        #1;
        check("done",      {31'b0, done},      {31'b0, m_done});
        check("result",    result,             m_res);
        check("sampleIrq", {31'b0, sampleIrq}, {31'b0, m_irq});
        cyc++;
    endtask

    task automatic op(input logic [2:0] code, input logic [31:0] b);
        cycle(1'b1, 8'h01, {29'b0, code}, b);
    endtask

    task automatic idle();
        cycle(1'b0, 8'h00, 32'h0, 32'h0);
    endtask

    initial begin
        logic [31:0] prev;
        int unsigned f;

        tbl[0]  = '{1'b1, 8'h01, 32'd4,        32'd0,  1'b1, 32'h0000_0000};
        tbl[1]  = '{1'b1, 8'h02, 32'd4,        32'd0,  1'b0, 32'h0000_0000};
        tbl[2]  = '{1'b0, 8'h01, 32'd4,        32'd0,  1'b0, 32'h0000_0000};
        tbl[3]  = '{1'b1, 8'h01, 32'd2,        32'd2,  1'b1, 32'h0000_0000};
        tbl[4]  = '{1'b1, 8'h01, 32'd3,        32'd0,  1'b1, 32'h0000_0000};
        tbl[5]  = '{1'b1, 8'h01, 32'd6,        32'hFF, 1'b1, 32'h0000_0000};
        tbl[6]  = '{1'b1, 8'h01, 32'd7,        32'hFF, 1'b1, 32'h0000_0000};
        tbl[7]  = '{1'b1, 8'h01, 32'd1,        32'd1,  1'b1, 32'h0000_0000};
        tbl[8]  = '{1'b1, 8'h01, 32'd4,        32'd0,  1'b1, 32'h4000_0000};
        tbl[9]  = '{1'b1, 8'h01, 32'd1,        32'd0,  1'b1, 32'h0000_0000};
        tbl[10] = '{1'b1, 8'h01, 32'h0000_0FFC, 32'd0, 1'b1, 32'h0000_0002};
        tbl[11] = '{1'b1, 8'h01, 32'd5,        32'd0,  1'b1, 32'h0000_0000};
        tbl[12] = '{1'b1, 8'h01, 32'd4,        32'd0,  1'b1, 32'h0000_0000};

        model_reset();
        #2 reset = 1'b0;
        #2;
        check("rst_done",   {31'b0, done},      32'd0);
        check("rst_result", result,             32'd0);
        check("rst_irq",    {31'b0, sampleIrq}, 32'd0);
        @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < 13; i++) begin
            cycle(tbl[i].st, tbl[i].n, tbl[i].a, tbl[i].b);
            check($sformatf("tbl%0d_done", i), {31'b0, done}, {31'b0, tbl[i].ed});
            check($sformatf("tbl%0d_result", i), result, tbl[i].er);
        end

        // Interval 4: one sample every 5 running cycles.
        op(3'd0, 32'd4);
        op(3'd1, 32'd1);
        repeat (20) idle();
        op(3'd4, 32'd0);
        check("status_int4", result, 32'h4000_0004);
        op(3'd3, 32'd0);
        prev = result;
        for (int k = 1; k < 4; k++) begin
            op(3'd3, 32'd0);
            check("pop_step5", result, prev + 32'd5);
            prev = result;
        end
        op(3'd1, 32'd0);

        // Interval 0: fills the FIFO and overflows.
        op(3'd5, 32'd0);
        op(3'd0, 32'd0);
        op(3'd1, 32'd1);
        repeat (12) idle();
        op(3'd4, 32'd0);
        check("status_ovf", result, 32'hC000_0008);
        check("irq_full", {31'b0, sampleIrq}, 32'd1);
        op(3'd5, 32'd0);
        op(3'd4, 32'd0);
        check("status_clr", result, 32'h4000_0000);

        // Full FIFO with a sample and a POP in the same cycle.
        op(3'd1, 32'd0);
        op(3'd5, 32'd0);
        op(3'd1, 32'd1);
        f = cyc;
        repeat (8) idle();
        op(3'd3, 32'd0);
        check("pop_full", result, f);
        op(3'd4, 32'd0);
        check("status_full_pop", result, 32'h4000_0008);
        op(3'd1, 32'd0);
        op(3'd2, 32'd2);
        check("peek2", result, ramp2(f + 1));
        op(3'd4, 32'd0);
        check("peek_count", result, 32'h8000_0008);
        for (int unsigned k = 0; k < 8; k++) begin
            op(3'd3, 32'd0);
            check("drain", result, f + 32'd1 + k);
        end
        op(3'd3, 32'd0);
        check("pop_empty", result, 32'd0);
        op(3'd4, 32'd0);
        check("status_empty", result, 32'h8000_0000);

        // Asynchronous reset while running with three entries stored.
        op(3'd5, 32'd0);
        op(3'd1, 32'd1);
        idle();
        idle();
        op(3'd4, 32'd0);
        check("status_pre_rst", result, 32'h4000_0002);
        #2 reset = 1'b0;
        start = 1'b0;
        #1;
        check("midrst_done",   {31'b0, done},      32'd0);
        check("midrst_result", result,             32'd0);
        check("midrst_irq",    {31'b0, sampleIrq}, 32'd0);
        model_reset();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        op(3'd4, 32'd0);
        check("status_after_rst", result, 32'd0);
        repeat (5) idle();
        op(3'd4, 32'd0);
        check("no_samples", result, 32'd0);

        // Randomized traffic against the model.
        rnd_cnt = 1'b1;
        for (int i = 0; i < 400; i++) begin
            bit          st;
            logic [7:0]  n;
            logic [31:0] a;
            logic [31:0] b;
            st = ($urandom_range(0, 3) != 0);
            n  = ($urandom_range(0, 4) == 0) ? 8'h02 : 8'h01;
            a  = $urandom;
            if (a[2:0] == 3'd5 && $urandom_range(0, 3) != 0) a[2:0] = 3'd4;
            b  = (a[2:0] == 3'd0) ? $urandom_range(0, 5) : $urandom;
            cycle(st, n, a, b);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
